// File: rtl/sram_word_controller.sv
// Splits one CPU word access into WORD_W/SRAM_DW asynchronous-SRAM beats (MSB half first),
// with WAIT_CYCLES+1 cycles per beat. Optional byte-masked writes under SRAM_BYTE_MASK_EN.
module sram_word_controller #(
  parameter int WORD_W      = 32,
  parameter int SRAM_DW     = 16,
  parameter int SRAM_AW     = 18,
  parameter int ADDR_W      = 32,
  parameter int BASE_ADDR   = 1024,
  parameter int WAIT_CYCLES = 2
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                read_enable,
  input  logic                write_enable,
  input  logic [ADDR_W-1:0]   address,
  input  logic [WORD_W-1:0]   write_data,
`ifdef SRAM_BYTE_MASK_EN
  input  logic [WORD_W/8-1:0] byte_en,
`endif
  output logic [WORD_W-1:0]   read_data,
  output logic                ready,
  output logic                addr_err,
  inout  wire  [SRAM_DW-1:0]  SRAM_DQ,
  output logic [SRAM_AW-1:0]  SRAM_ADDR,
  output logic                SRAM_UB_N,
  output logic                SRAM_LB_N,
  output logic                SRAM_WE_N,
  output logic                SRAM_CE_N,
  output logic                SRAM_OE_N
);

  localparam int BEATS  = WORD_W / SRAM_DW;
  localparam int OFF_W  = $clog2(WORD_W / 8);
  localparam int BEAT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int CYC_W  = $clog2(WAIT_CYCLES + 1);
  localparam logic [ADDR_W-1:0] BASE      = ADDR_W'(BASE_ADDR);
  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BEATS - 1);
  localparam logic [CYC_W-1:0]  LAST_CYC  = CYC_W'(WAIT_CYCLES);
  localparam logic [63:0]       SRAM_WORDS = 64'd1 << SRAM_AW;

  typedef enum logic [1:0] {IDLE = 2'd0, ACCESS = 2'd1, DONE = 2'd2} state_t;

  state_t              state, state_next;
  logic                wr, wr_next;
  logic [BEAT_W-1:0]   beat, beat_next;
  logic [CYC_W-1:0]    cyc, cyc_next;
  logic [SRAM_AW-1:0]  base, base_next;
  logic [WORD_W-1:0]   wbuf, wbuf_next;
  logic [WORD_W-1:0]   rbuf, rbuf_next;
  logic                err_pend, err_next;
  logic [WORD_W-1:0]   rdata_next;
  logic [ADDR_W-1:0]   widx;
  logic [63:0]         first_beat;
  logic                req, in_range;
  logic                acc, beat_we, ub_sel, lb_sel;
  logic [SRAM_AW-1:0]  addr_next;
  logic                dq_oe;
  logic [SRAM_DW-1:0]  dq_out;

  assign req        = read_enable | write_enable;
  assign widx       = (address - BASE) >> OFF_W;
  assign first_beat = 64'(widx) * 64'(BEATS);
  assign in_range   = (address >= BASE) && ((first_beat + 64'(BEATS - 1)) < SRAM_WORDS);

  assign SRAM_DQ = dq_oe ? dq_out : {SRAM_DW{1'bz}};

`ifdef SRAM_BYTE_MASK_EN
  localparam int WB  = WORD_W / 8;
  localparam int BPB = SRAM_DW / 8;
  localparam int HB  = BPB / 2;
  logic [WB-1:0]  mask, mask_next;
  logic [BPB-1:0] bmask;
  // Per-beat byte mask drives UB/LB; an all-zero beat suppresses the write strobe.
  assign bmask   = mask_next[WB-1 -: BPB];
  assign beat_we = wr_next ? (|bmask) : 1'b1;
  assign ub_sel  = wr_next ? ~(|bmask[BPB-1 -: HB]) : 1'b0;
  assign lb_sel  = wr_next ? ~(|bmask[HB-1:0]) : 1'b0;
`else
  assign beat_we = 1'b1;
  assign ub_sel  = 1'b0;
  assign lb_sel  = 1'b0;
`endif

  // Pipeline hold: combinational in IDLE so a new request stalls in its first cycle.
  always_comb begin
    ready = 1'b1;
    case (state)
      IDLE:    ready = ~req;
      ACCESS:  ready = 1'b0;
      DONE:    ready = 1'b1;
      default: ready = 1'b1;
    endcase
  end

  // Next-state, operand latching, beat/cycle sequencing and read assembly.
  always_comb begin
    state_next = state;
    wr_next    = wr;
    beat_next  = beat;
    cyc_next   = cyc;
    base_next  = base;
    wbuf_next  = wbuf;
    rbuf_next  = rbuf;
    err_next   = err_pend;
    rdata_next = read_data;
`ifdef SRAM_BYTE_MASK_EN
    mask_next  = mask;
`endif
    case (state)
      IDLE: begin
        if (req && in_range) begin
          state_next = ACCESS;
          wr_next    = ~read_enable;
          beat_next  = '0;
          cyc_next   = '0;
          base_next  = SRAM_AW'(first_beat);
          wbuf_next  = write_data;
`ifdef SRAM_BYTE_MASK_EN
          mask_next  = byte_en;
`endif
        end else if (req) begin
          state_next = DONE;
          err_next   = 1'b1;
          rdata_next = read_enable ? '0 : read_data;
        end else begin
          state_next = IDLE;
        end
      end
      ACCESS: begin
        if (cyc == LAST_CYC) begin
          cyc_next  = '0;
          rbuf_next = wr ? rbuf : ((rbuf << SRAM_DW) | WORD_W'(SRAM_DQ));
          if (beat == LAST_BEAT) begin
            state_next = DONE;
            rdata_next = wr ? read_data : rbuf_next;
          end else begin
            beat_next = beat + BEAT_W'(1);
            wbuf_next = wbuf << SRAM_DW;
`ifdef SRAM_BYTE_MASK_EN
            mask_next = mask << BPB;
`endif
          end
        end else begin
          cyc_next = cyc + CYC_W'(1);
        end
      end
      DONE: begin
        state_next = IDLE;
        err_next   = 1'b0;
      end
      default: state_next = IDLE;
    endcase
  end

  // SRAM pins are registered from the next-cycle view so they never glitch.
  assign acc       = (state_next == ACCESS);
  assign addr_next = acc ? (base_next + SRAM_AW'(beat_next)) : SRAM_ADDR;

  // State and registered outputs; reset forces the SRAM bus idle immediately.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      wr        <= 1'b0;
      beat      <= '0;
      cyc       <= '0;
      base      <= '0;
      wbuf      <= '0;
      rbuf      <= '0;
      err_pend  <= 1'b0;
      read_data <= '0;
      addr_err  <= 1'b0;
      SRAM_ADDR <= '0;
      SRAM_CE_N <= 1'b1;
      SRAM_OE_N <= 1'b1;
      SRAM_WE_N <= 1'b1;
      SRAM_UB_N <= 1'b1;
      SRAM_LB_N <= 1'b1;
      dq_oe     <= 1'b0;
      dq_out    <= '0;
`ifdef SRAM_BYTE_MASK_EN
      mask      <= '0;
`endif
    end else begin
      state     <= state_next;
      wr        <= wr_next;
      beat      <= beat_next;
      cyc       <= cyc_next;
      base      <= base_next;
      wbuf      <= wbuf_next;
      rbuf      <= rbuf_next;
      err_pend  <= err_next;
      read_data <= rdata_next;
      addr_err  <= (state_next == DONE) && err_next;
      SRAM_ADDR <= addr_next;
      SRAM_CE_N <= ~acc;
      SRAM_OE_N <= ~(acc && !wr_next);
      SRAM_WE_N <= ~(acc && wr_next && beat_we && (cyc_next < LAST_CYC));
      SRAM_UB_N <= acc ? ub_sel : 1'b1;
      SRAM_LB_N <= acc ? lb_sel : 1'b1;
      dq_oe     <= acc && wr_next;
      dq_out    <= wbuf_next[WORD_W-1 -: SRAM_DW];
`ifdef SRAM_BYTE_MASK_EN
      mask      <= mask_next;
`endif
    end
  end

endmodule

// File: tb/tb_sram_word_controller.sv
// Self-checking bench for sram_word_controller with a behavioural async SRAM on a pulled-up bus.
module tb_sram_word_controller;

  logic        clk = 1'b0;
  logic        rst;
  logic        read_enable, write_enable;
  logic [31:0] address, write_data;
  logic [3:0]  byte_en;
  logic [31:0] read_data;
  logic        ready, addr_err;
  wire  [15:0] SRAM_DQ;
  logic [17:0] SRAM_ADDR;
  logic        SRAM_UB_N, SRAM_LB_N, SRAM_WE_N, SRAM_CE_N, SRAM_OE_N;

  always #5 clk = ~clk;

  sram_word_controller dut (
    .clk(clk), .rst(rst),
    .read_enable(read_enable), .write_enable(write_enable),
    .address(address), .write_data(write_data),
`ifdef SRAM_BYTE_MASK_EN
    .byte_en(byte_en),
`endif
    .read_data(read_data), .ready(ready), .addr_err(addr_err),
    .SRAM_DQ(SRAM_DQ), .SRAM_ADDR(SRAM_ADDR),
    .SRAM_UB_N(SRAM_UB_N), .SRAM_LB_N(SRAM_LB_N), .SRAM_WE_N(SRAM_WE_N),
    .SRAM_CE_N(SRAM_CE_N), .SRAM_OE_N(SRAM_OE_N)
  );

  // Undriven bus reads as all ones so a stray controller drive is visible.
  for (genvar g = 0; g < 16; g++) begin : g_pu
    pullup (SRAM_DQ[g]);
  end

  logic [15:0] mem [logic [17:0]];
  logic [15:0] rd_val = 16'h0000;
  logic        model_en = 1'b1;

  function automatic logic [15:0] peek(input logic [17:0] a);
    return mem.exists(a) ? mem[a] : 16'h0000;
  endfunction

  assign SRAM_DQ = (model_en && !SRAM_CE_N && !SRAM_OE_N) ? rd_val : 16'hzzzz;

  always @(negedge clk) begin
    logic [15:0] cur;
    if (!SRAM_CE_N && !SRAM_WE_N) begin
      cur = peek(SRAM_ADDR);
      if (!SRAM_UB_N) cur[15:8] = SRAM_DQ[15:8];
      if (!SRAM_LB_N) cur[7:0]  = SRAM_DQ[7:0];
      mem[SRAM_ADDR] = cur;
    end
    rd_val = peek(SRAM_ADDR);
  end

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, got, exp);
    end
  endtask

  int          r_lows, r_we, r_rule, r_done;
  logic        r_err, r_ce;
  logic [31:0] r_rd;
  logic [17:0] r_first, r_last;

  task automatic run_access(input logic re, input logic we, input logic [31:0] a, input logic [31:0] d);
    r_lows = 0; r_we = 0; r_rule = 0; r_done = 0; r_ce = 1'b0;
    r_err = 1'b0; r_rd = 32'h0; r_first = 18'h0; r_last = 18'h0;
    @(posedge clk); #1;
    read_enable = re; write_enable = we; address = a; write_data = d;
    for (int i = 0; i < 40 && r_done == 0; i++) begin
      @(negedge clk);
      if (!SRAM_CE_N) begin
        if (!r_ce) r_first = SRAM_ADDR;
        r_last = SRAM_ADDR;
        r_ce = 1'b1;
      end
      if (!SRAM_WE_N) r_we++;
      if (!SRAM_WE_N && !SRAM_OE_N) r_rule++;
      if (ready) begin
        r_done = 1; r_err = addr_err; r_rd = read_data;
      end else begin
        r_lows++;
      end
    end
    if (r_done == 0) check("access_timeout", 64'd0, 64'd1);
    @(posedge clk); #1;
    read_enable = 1'b0; write_enable = 1'b0;
  endtask

  typedef struct {
    string       name;
    logic        re;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    int          lows;
    int          we_low;
    logic        err;
    logic        ce;
    logic [17:0] a_first;
    logic [17:0] a_last;
    logic        chk_rd;
    logic [31:0] rd;
  } vec_t;

  vec_t vecs [11];

  initial begin
    vecs[0]  = '{"w_400",     1'b0, 1'b1, 32'h0000_0400, 32'hDEADBEEF, 7, 4, 1'b0, 1'b1, 18'h0,     18'h1,     1'b0, 32'h0};
    vecs[1]  = '{"w_40e",     1'b0, 1'b1, 32'h0000_040E, 32'h12345678, 7, 4, 1'b0, 1'b1, 18'h6,     18'h7,     1'b0, 32'h0};
    vecs[2]  = '{"r_40c",     1'b1, 1'b0, 32'h0000_040C, 32'h0,        7, 0, 1'b0, 1'b1, 18'h6,     18'h7,     1'b1, 32'h12345678};
    vecs[3]  = '{"r_3fc",     1'b1, 1'b0, 32'h0000_03FC, 32'h0,        1, 0, 1'b1, 1'b0, 18'h0,     18'h0,     1'b1, 32'h0};
    vecs[4]  = '{"w_404",     1'b0, 1'b1, 32'h0000_0404, 32'hCAFEF00D, 7, 4, 1'b0, 1'b1, 18'h2,     18'h3,     1'b0, 32'h0};
    vecs[5]  = '{"r_404",     1'b1, 1'b0, 32'h0000_0404, 32'h0,        7, 0, 1'b0, 1'b1, 18'h2,     18'h3,     1'b1, 32'hCAFEF00D};
    vecs[6]  = '{"rw_400",    1'b1, 1'b1, 32'h0000_0400, 32'h0,        7, 0, 1'b0, 1'b1, 18'h0,     18'h1,     1'b1, 32'hDEADBEEF};
    vecs[7]  = '{"w_top",     1'b0, 1'b1, 32'h0008_03FC, 32'h0BADC0DE, 7, 4, 1'b0, 1'b1, 18'h3FFFE, 18'h3FFFF, 1'b0, 32'h0};
    vecs[8]  = '{"r_top",     1'b1, 1'b0, 32'h0008_03FC, 32'h0,        7, 0, 1'b0, 1'b1, 18'h3FFFE, 18'h3FFFF, 1'b1, 32'h0BADC0DE};
    vecs[9]  = '{"w_oor",     1'b0, 1'b1, 32'h0008_0400, 32'hFFFF0000, 1, 0, 1'b1, 1'b0, 18'h0,     18'h0,     1'b1, 32'h0BADC0DE};
    vecs[10] = '{"r_oor",     1'b1, 1'b0, 32'h0008_0400, 32'h0,        1, 0, 1'b1, 1'b0, 18'h0,     18'h0,     1'b1, 32'h0};

    read_enable = 1'b0; write_enable = 1'b0; address = 32'h0; write_data = 32'h0; byte_en = 4'hF;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("rst_ready",     64'(ready),     64'd1);
    check("rst_addr_err",  64'(addr_err),  64'd0);
    check("rst_read_data", 64'(read_data), 64'd0);
    check("rst_sram_addr", 64'(SRAM_ADDR), 64'd0);
    check("rst_dq",        64'(SRAM_DQ),   64'hFFFF);
    check("rst_ctrl", 64'({SRAM_WE_N, SRAM_OE_N, SRAM_CE_N, SRAM_UB_N, SRAM_LB_N}), 64'h1F);
    @(negedge clk); rst = 1'b0;

    for (int i = 0; i < 11; i++) begin
      run_access(vecs[i].re, vecs[i].we, vecs[i].addr, vecs[i].wdata);
      check({vecs[i].name, "_lows"},  64'(r_lows), 64'(vecs[i].lows));
      check({vecs[i].name, "_we"},    64'(r_we),   64'(vecs[i].we_low));
      check({vecs[i].name, "_err"},   64'(r_err),  64'(vecs[i].err));
      check({vecs[i].name, "_ce"},    64'(r_ce),   64'(vecs[i].ce));
      check({vecs[i].name, "_rule"},  64'(r_rule), 64'd0);
      if (vecs[i].ce) begin
        check({vecs[i].name, "_afirst"}, 64'(r_first), 64'(vecs[i].a_first));
        check({vecs[i].name, "_alast"},  64'(r_last),  64'(vecs[i].a_last));
      end
      if (vecs[i].chk_rd) check({vecs[i].name, "_rdata"}, 64'(r_rd), 64'(vecs[i].rd));
    end

    check("mem0", 64'(peek(18'h0)), 64'hDEAD);
    check("mem1", 64'(peek(18'h1)), 64'hBEEF);
    check("mem6", 64'(peek(18'h6)), 64'h1234);
    check("mem7", 64'(peek(18'h7)), 64'h5678);

    // Reset in the third cycle of a write (second ACCESS cycle, strobe low).
    run_access(1'b1, 1'b0, 32'h400, 32'h0);
    check("pre_rst_rdata", 64'(r_rd), 64'hDEADBEEF);
    @(posedge clk); #1;
    write_enable = 1'b1; address = 32'h400; write_data = 32'h11112222;
    repeat (2) @(posedge clk);
    #2;
    check("mid_we_low", 64'(SRAM_WE_N), 64'd0);
    rst = 1'b1;
    #1;
    check("mid_rst_we", 64'(SRAM_WE_N), 64'd1);
    check("mid_rst_ce", 64'(SRAM_CE_N), 64'd1);
    check("mid_rst_dq", 64'(SRAM_DQ),   64'hFFFF);
    check("mid_rst_rd", 64'(read_data), 64'd0);
    write_enable = 1'b0;
    @(negedge clk); rst = 1'b0;
    run_access(1'b0, 1'b1, 32'h400, 32'h55667788);
    check("post_rst_lows", 64'(r_lows), 64'd7);
    check("post_rst_we",   64'(r_we),   64'd4);
    run_access(1'b1, 1'b0, 32'h400, 32'h0);
    check("post_rst_rdata", 64'(r_rd), 64'h55667788);

    // With the SRAM model silent the bus must stay pulled up: the controller never drives on reads.
    model_en = 1'b0;
    run_access(1'b1, 1'b0, 32'h400, 32'h0);
    check("float_rdata", 64'(r_rd),   64'hFFFFFFFF);
    check("float_lows",  64'(r_lows), 64'd7);
    model_en = 1'b1;

`ifdef SRAM_BYTE_MASK_EN
    run_access(1'b0, 1'b1, 32'h400, 32'hDEADBEEF);
    byte_en = 4'b0011;
    run_access(1'b0, 1'b1, 32'h400, 32'hAABBCCDD);
    check("mask_we",   64'(r_we),   64'd2);
    check("mask_lows", 64'(r_lows), 64'd7);
    byte_en = 4'hF;
    run_access(1'b1, 1'b0, 32'h400, 32'h0);
    check("mask_rdata", 64'(r_rd), 64'hDEADCCDD);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
